// File: rtl/rs232_pkg.sv
// Constants and receiver FSM encoding shared by the rs232 receiver and transmitter.
package rs232_pkg;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;
  localparam int MID_SAMPLE     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchronizer for an asynchronous level; 2 clk latency, no backpressure.
module rs232_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 oversampling UART receiver; byte visible one clk after the stop sample.
// One-entry output register: completions while unacknowledged are dropped and flagged as overrun.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rxd_s;
  logic                 complete;

  rs232_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    complete = 1'b0;
    ferr_d   = 1'b0;
    if (rx_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxd_s;
            if (idx_q == IDX_LAST) state_d = ST_STOP;
            else                   idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxd_s) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // A held break stays here silently until the line returns high.
          if (rxd_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A completion coinciding with an accepted ack replaces the byte and keeps overrun as is.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: vector table, directed corner sequences and a randomized frame stream.
module tb_rs232_rx;
  import rs232_pkg::*;

  localparam int OS = OVERSAMPLE_DEF;
  localparam int DB = DATA_BITS_DEF;
  // rx_en strobes from start detection to the stop-bit sample
  localparam int FRAME_EN = MID_SAMPLE + 1 + OS * DB + OS;

  typedef struct {
    logic [7:0] payload;
    logic       stop;
    logic       do_ack;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_en = 1'b0;
  logic          rxd = 1'b1;
  logic          ack = 1'b0;
  logic [DB-1:0] data;
  logic          valid;
  logic          framing_err;
  logic          overrun;

  int n_chk = 0;
  int n_pass = 0;
  int ferr_cnt = 0;
  int cyc_n = 0;
  int en_period = 4;
  int ack_cyc = -1;

  rs232_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .rxd         (rxd),
    .data        (data),
    .valid       (valid),
    .ack         (ack),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (framing_err === 1'b1) ferr_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int bc();
    return OS * en_period;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
    rx_en = ((cyc_n % en_period) == 0);
    ack   = (cyc_n == ack_cyc);
  endtask

  task automatic drive_bit(input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rxd = val;
    end
  endtask

  task automatic ack_pulse();
    ack_cyc = cyc_n + 1;
    step();
    step();
  endtask

  // Start bit appears on rxd in cycle cyc_n+1 and reaches the receiver two clks later;
  // the stop sample is FRAME_EN strobes after the first strobe that sees it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle_bits,
                            input logic ack_done, output int done_cyc);
    int c;
    c = cyc_n + 3;
    while ((c % en_period) != 0) c++;
    done_cyc = c + FRAME_EN * en_period;
    if (ack_done) ack_cyc = done_cyc;
    drive_bit(1'b0, bc());
    for (int i = 0; i < DB; i++) drive_bit(b[i], bc());
    drive_bit(stop, bc());
    drive_bit(1'b1, idle_bits * bc());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd   = 1'b1;
    step();
    step();
    reset = 1'b0;
    drive_bit(1'b1, 2 * bc());
  endtask

  initial begin
    vec_t       vecs[6];
    int         f0, dc;
    logic [7:0] b;
    logic       good, ack_mid, m_valid, m_ovr;
    logic [7:0] m_data;
    int         m_ferr;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 0};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[5] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 0};

    #2 reset = 1'b1;
    #1;
    check("reset data", 32'(data), 0);
    check("reset valid", 32'(valid), 0);
    check("reset framing_err", 32'(framing_err), 0);
    check("reset overrun", 32'(overrun), 0);
    step();
    step();
    reset = 1'b0;
    drive_bit(1'b1, 2 * bc());

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].payload, vecs[i].stop, 2, 1'b0, dc);
      check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d framing pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
      if (vecs[i].do_ack) begin
        ack_pulse();
        check($sformatf("vec%0d valid after ack", i), 32'(valid), 0);
        check($sformatf("vec%0d overrun after ack", i), 32'(overrun), 0);
      end
    end

    // False start: two low strobes then high.
    f0 = ferr_cnt;
    drive_bit(1'b0, 2 * en_period);
    drive_bit(1'b1, 2 * bc());
    check("false start valid", 32'(valid), 0);
    check("false start framing", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, 2, 1'b0, dc);
    check("after false start valid", 32'(valid), 1);
    check("after false start data", 32'(data), 32'h3C);
    ack_pulse();

    // Bad stop followed by a 20-bit break, then a clean frame.
    f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, 0, 1'b0, dc);
    drive_bit(1'b0, 20 * bc());
    drive_bit(1'b1, 2 * bc());
    send_frame(8'h55, 1'b1, 2, 1'b0, dc);
    check("break framing pulses", ferr_cnt - f0, 1);
    check("break valid", 32'(valid), 1);
    check("break data", 32'(data), 32'h55);
    check("break overrun", 32'(overrun), 0);
    ack_pulse();

    // ack on the exact completion cycle replaces the held byte.
    send_frame(8'h11, 1'b1, 2, 1'b0, dc);
    check("hold 11 data", 32'(data), 32'h11);
    send_frame(8'h22, 1'b1, 2, 1'b1, dc);
    check("ack at completion data", 32'(data), 32'h22);
    check("ack at completion valid", 32'(valid), 1);
    check("ack at completion overrun", 32'(overrun), 0);
    ack_pulse();
    check("ack at completion released", 32'(valid), 0);

    // Reset during data bit 4, then receive with rx_en tied high.
    send_frame(8'h12, 1'b1, 2, 1'b0, dc);
    send_frame(8'h34, 1'b1, 2, 1'b0, dc);
    check("pre-reset overrun", 32'(overrun), 1);
    check("pre-reset data", 32'(data), 32'h12);
    b = 8'hC3;
    drive_bit(1'b0, bc());
    for (int i = 0; i < 4; i++) drive_bit(b[i], bc());
    drive_bit(b[4], bc() / 2);
    f0 = ferr_cnt;
    reset = 1'b1;
    #1;
    check("mid-frame reset data", 32'(data), 0);
    check("mid-frame reset valid", 32'(valid), 0);
    check("mid-frame reset overrun", 32'(overrun), 0);
    check("mid-frame reset framing_err", 32'(framing_err), 0);
    rxd = 1'b1;
    step();
    step();
    reset = 1'b0;
    en_period = 1;
    drive_bit(1'b1, 4 * bc());
    check("post-reset valid", 32'(valid), 0);
    check("post-reset framing", ferr_cnt - f0, 0);
    send_frame(8'h81, 1'b1, 2, 1'b0, dc);
    check("rx_en high valid", 32'(valid), 1);
    check("rx_en high data", 32'(data), 32'h81);
    check("rx_en high overrun", 32'(overrun), 0);

    // Randomized frames against a byte-level model of the one-entry handshake.
    do_reset();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
    m_ferr  = ferr_cnt;
    for (int k = 0; k < 24; k++) begin
      en_period = ($urandom_range(0, 2) == 0) ? 1 : 4;
      drive_bit(1'b1, $urandom_range(0, 7));
      b       = 8'($urandom);
      good    = ($urandom_range(0, 3) != 0);
      ack_mid = m_valid && ($urandom_range(0, 3) == 0);
      send_frame(b, good, 2, ack_mid, dc);
      if (good) begin
        if (!m_valid || ack_mid) begin
          m_data  = b;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_ferr++;
        if (ack_mid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      check($sformatf("rnd%0d valid", k), 32'(valid), 32'(m_valid));
      check($sformatf("rnd%0d data", k), 32'(data), 32'(m_data));
      check($sformatf("rnd%0d overrun", k), 32'(overrun), 32'(m_ovr));
      check($sformatf("rnd%0d framing pulses", k), ferr_cnt, m_ferr);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        check($sformatf("rnd%0d valid after ack", k), 32'(valid), 32'(m_valid));
        check($sformatf("rnd%0d overrun after ack", k), 32'(overrun), 32'(m_ovr));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 8: rx_en strobes per bit time.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, 8N1 framing, LSB first.
REQ-003 Port clk  input  1  rs232 clock (CLKRS232 domain); all flops on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx_en  input  1  8x-baud enable strobe, one clk wide; state advances only on cycles with rx_en=1.
REQ-006 Port rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-007 Port data  output  DATA_BITS  last received byte.
REQ-008 Port valid  output  1  data holds an unacknowledged byte.
REQ-009 Port ack  input  1  consumer accepts data; ignored while valid=0.
REQ-010 Port framing_err  output  1  one-clk pulse on a bad stop bit.
REQ-011 Port overrun  output  1  sticky; a completed byte was dropped.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer clocked every clk (not gated by rx_en); the synchronizer resets to 1; all decisions use the synchronized value.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE; a sample counter (0..OVERSAMPLE-1) and bit index (0..DATA_BITS-1).
REQ-014 IDLE: on rx_en with rxd=0 -> START, counter=0.
REQ-015 START: counter increments per rx_en; on the rx_en where counter=3 (mid-bit), rxd=0 -> DATA with counter=0 and bit index=0; rxd=1 -> IDLE (false start, no outputs change).
REQ-016 DATA: counter increments per rx_en; on the rx_en where counter=OVERSAMPLE-1, rxd is shifted into bit[index], counter wraps to 0; after bit DATA_BITS-1 -> STOP.
REQ-017 STOP: sample on the rx_en where counter=OVERSAMPLE-1; rxd=1 -> byte completes, IDLE; rxd=0 -> framing_err=1 for exactly the next clk, byte discarded, -> WAIT_IDLE.
REQ-018 WAIT_IDLE: on rx_en with rxd=1 -> IDLE; line held low (break) produces no further framing_err and no valid.
REQ-019 Completion latency: data and valid update on the clk edge after the stop-sampling rx_en cycle.
REQ-020 Handshake: valid stays 1 until a clk with valid=1 and ack=1; valid=0 on the following clk unless a completion occurs on that same cycle.
REQ-021 Completion while valid=1 and ack=0: new byte dropped, data unchanged, overrun=1.
REQ-022 Completion on the same cycle as ack with valid=1: new byte loaded, valid remains 1, overrun unchanged.
REQ-023 overrun clears on an accepted ack (valid=1, ack=1) unless REQ-021 sets it on the same cycle (set wins).
REQ-024 rx_en held high continuously is legal; behaviour equals OVERSAMPLE samples per OVERSAMPLE clks.

Reset
REQ-025 Asynchronous reset SHALL force: state=IDLE, counters=0, shift register=0, data=0, valid=0, framing_err=0, overrun=0, synchronizer=1.
REQ-026 Reset mid-frame abandons the frame; no valid or framing_err results from the partial frame.

Structure
REQ-027 Package rs232_pkg SHALL hold the FSM state enum, OVERSAMPLE, MID_SAMPLE=3 and DATA_BITS defaults, shared with the rs232 transmitter.
REQ-028 One sub-module: rs232_rx_sync (2-flop synchronizer, reset value parameterised); everything else inline.

Verification (rx_en every 4 clks unless noted)
REQ-029 Frame 0xA5, good stop -> valid=1, data=0xA5, framing_err=0, overrun=0; ack one clk -> valid=0 next clk.
REQ-030 rxd low for 2 rx_en then high -> no valid, FSM in IDLE; following frame 0x3C received correctly.
REQ-031 Frame 0xFF with stop=0, line then low 20 bit times, then frame 0x55 -> exactly one framing_err pulse, only 0x55 delivered.
REQ-032 Frames 0x11 then 0x22, no ack -> data=0x11, overrun=1; ack -> valid=0, overrun=0.
REQ-033 ack asserted on the completion cycle of 0x22 while holding 0x11 -> data=0x22, valid=1, overrun=0.
REQ-034 reset pulsed during data bit 4 -> all outputs at reset values immediately; after release, frame 0x81 with rx_en tied high received correctly.
